// File: rtl/piso_serializer_if.sv
// rtl/piso_serializer_if.sv - load handshake and serial stream bundle for piso_serializer
`timescale 1ns/1ps
interface piso_serializer_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] parallel_in;
   logic             shift_en;
   logic             serial_out;
   logic             out_valid;
   logic             last;

   modport master (
      output in_valid, parallel_in, shift_en,
      input  in_ready, serial_out, out_valid, last
   );

   modport slave (
      input  in_valid, parallel_in, shift_en,
      output in_ready, serial_out, out_valid, last
   );
endinterface

// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - parallel-in serial-out shifter; define PISO_PARITY_EN to append an even-parity bit
`timescale 1ns/1ps
module piso_serializer #(
   parameter int WIDTH     = 8,
   parameter bit LSB_FIRST = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   piso_serializer_if.slave bus
);
   localparam int CNT_W = $clog2(WIDTH + 1);
`ifdef PISO_PARITY_EN
   localparam int FRAME_LEN = WIDTH + 1;
`else
   localparam int FRAME_LEN = WIDTH;
`endif
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_LEN - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] shift_reg;
   logic [WIDTH-1:0] shift_nxt;
   logic [CNT_W-1:0] cnt;
   logic             at_last;
   logic             out_end;
   logic             data_bit;
   logic             ready;
   logic             accept;

   assign at_last   = (cnt == LAST_CNT);
   assign out_end   = LSB_FIRST ? shift_reg[0] : shift_reg[WIDTH-1];
   assign shift_nxt = LSB_FIRST ? (shift_reg >> 1) : (shift_reg << 1);

`ifdef PISO_PARITY_EN
   logic parity_q;

   // Parity is latched with the word so later parallel_in changes cannot disturb it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_q <= 1'b0;
      end else if (accept) begin
         parity_q <= ^bus.parallel_in;
      end
   end

   assign data_bit = (cnt == CNT_W'(WIDTH)) ? parity_q : out_end;
`else
   assign data_bit = out_end;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt      = state;
      ready          = 1'b0;
      accept         = 1'b0;
      bus.out_valid  = 1'b0;
      bus.last       = 1'b0;
      bus.serial_out = 1'b0;
      case (state)
         IDLE: begin
            ready  = 1'b1;
            accept = bus.in_valid;
            if (accept) begin
               state_nxt = SHIFT;
            end
         end
         SHIFT: begin
            bus.out_valid  = 1'b1;
            bus.last       = at_last;
            bus.serial_out = data_bit;
            ready          = at_last & bus.shift_en;
            accept         = bus.in_valid & ready;
            if (at_last && bus.shift_en && !accept) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
      bus.in_ready = ready;
   end

   // A reload on the last bit restarts the frame with no idle gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shift_reg <= '0;
         cnt       <= '0;
      end else if (accept) begin
         shift_reg <= bus.parallel_in;
         cnt       <= '0;
      end else if (state == SHIFT && bus.shift_en) begin
         shift_reg <= shift_nxt;
         cnt       <= at_last ? '0 : cnt + CNT_W'(1);
      end
   end
endmodule
